apo_input_arbiter: RTL and testbench

Input scheduler in front of an `apo_router` core in the circulant NoC (C(36; 4, 5) configuration). The core has five 13-bit packet inputs and serves only one packet per cycle under fixed priority, so it silently loses the others. This block removes that loss. It buffers each of the five input streams (local `free`, `r1R`, `r2R`, `r1L`, `r2L`) in a small FIFO and grants one packet per cycle to the core by round-robin. It holds the granted packet until the core accepts it.

---
 rtl/apo_input_arbiter.sv | 234 +++++++++++++++++++++++
 tb/tb_apo_input_arbiter.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/apo_input_arbiter.sv
// -----------------------------------------------------------------------------
// apo_input_arbiter
//
// Input scheduler in front of an apo_router core. Each of the five packet
// inputs (free, r1R, r2R, r1L, r2L) is buffered in its own DEPTH-entry FIFO.
// One packet per cycle is granted to the core by round-robin. The granted
// packet is held on out_pkt until the core accepts it with core_ready.
//
// Ports
//   clk        : clock, rising edge
//   rst_n      : asynchronous active-low reset
//   in_free    : packet from the local node      (bit N2-1 = valid)
//   in_r1R     : packet from right neighbour, s1 (bit N2-1 = valid)
//   in_r2R     : packet from right neighbour, s2 (bit N2-1 = valid)
//   in_r1L     : packet from left neighbour, s1  (bit N2-1 = valid)
//   in_r2L     : packet from left neighbour, s2  (bit N2-1 = valid)
//   core_ready : core accepts out_pkt this cycle (ignored when idle)
//   out_pkt    : packet offered to the core, zero when idle
//   out_grant  : one-hot source of out_pkt (0 free,1 r1R,2 r2R,3 r1L,4 r2L)
//   in_full    : registered per-input FIFO full flags, same bit order
//   drop_cnt   : saturating count of packets dropped on a full FIFO
// -----------------------------------------------------------------------------
module apo_input_arbiter #(
  parameter int N2    = 13,
  parameter int DEPTH = 2,
  parameter int CW    = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N2-1:0] in_free,
  input  logic [N2-1:0] in_r1R,
  input  logic [N2-1:0] in_r2R,
  input  logic [N2-1:0] in_r1L,
  input  logic [N2-1:0] in_r2L,
  input  logic          core_ready,
  output logic [N2-1:0] out_pkt,
  output logic [4:0]    out_grant,
  output logic [4:0]    in_full,
  output logic [CW-1:0] drop_cnt
);

  localparam int NIN  = 5;
  localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNTW = $clog2(DEPTH + 1);

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_HOLD  = 1'b1
  } state_t;

  // ---------------------------------------------------------------------------
  // Storage and state
  // ---------------------------------------------------------------------------
  logic [N2-1:0]   r_mem   [NIN][DEPTH];
  logic [PW-1:0]   r_wptr  [NIN];
  logic [PW-1:0]   r_rptr  [NIN];
  logic [CNTW-1:0] r_cnt   [NIN];
  logic [4:0]      r_full;
  logic [CW-1:0]   r_drop_cnt;

  state_t          r_state;
  logic [N2-1:0]   r_out_pkt;
  logic [4:0]      r_out_grant;
  logic [2:0]      r_last;

  // ---------------------------------------------------------------------------
  // Combinational decode
  // ---------------------------------------------------------------------------
  logic [N2-1:0]   w_in       [NIN];
  logic [4:0]      w_nonempty;
  logic [4:0]      w_at_depth;
  logic [4:0]      w_push;
  logic [4:0]      w_drop;
  logic [4:0]      w_pop;
  logic [CNTW-1:0] w_cnt_nxt  [NIN];
  logic            w_take;
  logic [2:0]      w_win_idx;
  logic [N2-1:0]   w_head;
  logic [2:0]      w_drop_n;
  logic [CW:0]     w_drop_sum;

  assign w_in[0] = in_free;
  assign w_in[1] = in_r1R;
  assign w_in[2] = in_r2R;
  assign w_in[3] = in_r1L;
  assign w_in[4] = in_r2L;

  // Push/drop are judged on the pre-edge count only, so a packet that meets a
  // full FIFO is dropped even when that FIFO is popped on the same edge.
  always_comb begin
    for (int unsigned i = 0; i < NIN; i++) begin
      w_nonempty[i] = (r_cnt[i] != '0);
      w_at_depth[i] = (r_cnt[i] == CNTW'(DEPTH));
      w_push[i]     = w_in[i][N2-1] && !w_at_depth[i];
      w_drop[i]     = w_in[i][N2-1] &&  w_at_depth[i];
    end
  end

  // Round-robin search starting one past the last grant, wrapping at 5.
  always_comb begin
    int unsigned idx;
    logic        found;
    found     = 1'b0;
    idx       = 0;
    w_win_idx = '0;
    for (int unsigned k = 1; k <= NIN; k++) begin
      idx = (32'(r_last) + k) % NIN;
      if (!found && w_nonempty[idx]) begin
        found     = 1'b1;
        w_win_idx = 3'(idx);
      end
    end
  end

  // A new packet is loaded when the output is idle or the held packet is
  // being accepted on this edge.
  assign w_take = ((r_state == S_EMPTY) || core_ready) && (w_nonempty != '0);

  always_comb begin
    w_head = '0;
    w_pop  = '0;
    for (int unsigned i = 0; i < NIN; i++) begin
      if (w_win_idx == 3'(i)) begin
        w_head   = r_mem[i][r_rptr[i]];
        w_pop[i] = w_take;
      end
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < NIN; i++) begin
      case ({w_push[i], w_pop[i]})
        2'b10:   w_cnt_nxt[i] = r_cnt[i] + CNTW'(1);
        2'b01:   w_cnt_nxt[i] = r_cnt[i] - CNTW'(1);
        default: w_cnt_nxt[i] = r_cnt[i];
      endcase
    end
  end

  always_comb begin
    w_drop_n = '0;
    for (int unsigned i = 0; i < NIN; i++) begin
      w_drop_n = w_drop_n + 3'(w_drop[i]);
    end
    w_drop_sum = {1'b0, r_drop_cnt} + (CW+1)'(w_drop_n);
  end

  // ---------------------------------------------------------------------------
  // FIFO data storage (no reset needed: contents are qualified by r_cnt)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NIN; i++) begin
      if (w_push[i]) begin
        r_mem[i][r_wptr[i]] <= w_in[i];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // FIFO pointers, counts, full flags and drop counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NIN; i++) begin
        r_wptr[i] <= '0;
        r_rptr[i] <= '0;
        r_cnt[i]  <= '0;
      end
      r_full     <= '0;
      r_drop_cnt <= '0;
    end else begin
      for (int unsigned i = 0; i < NIN; i++) begin
        if (w_push[i]) begin
          r_wptr[i] <= r_wptr[i] + PW'(1);
        end
        if (w_pop[i]) begin
          r_rptr[i] <= r_rptr[i] + PW'(1);
        end
        r_cnt[i]  <= w_cnt_nxt[i];
        r_full[i] <= (w_cnt_nxt[i] == CNTW'(DEPTH));
      end
      if (w_drop_sum[CW]) begin
        r_drop_cnt <= '1;
      end else begin
        r_drop_cnt <= w_drop_sum[CW-1:0];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output FSM with registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_EMPTY;
      r_out_pkt   <= '0;
      r_out_grant <= '0;
      r_last      <= 3'd4;
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (w_take) begin
            r_out_pkt   <= w_head;
            r_out_grant <= 5'b00001 << w_win_idx;
            r_last      <= w_win_idx;
            r_state     <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (w_take) begin
            r_out_pkt   <= w_head;
            r_out_grant <= 5'b00001 << w_win_idx;
            r_last      <= w_win_idx;
          end else if (core_ready) begin
            r_out_pkt   <= '0;
            r_out_grant <= '0;
            r_state     <= S_EMPTY;
          end
        end
        default: begin
          r_state     <= S_EMPTY;
          r_out_pkt   <= '0;
          r_out_grant <= '0;
        end
      endcase
    end
  end

  assign out_pkt   = r_out_pkt;
  assign out_grant = r_out_grant;
  assign in_full   = r_full;
  assign drop_cnt  = r_drop_cnt;

endmodule

// File: tb/tb_apo_input_arbiter.sv
// -----------------------------------------------------------------------------
// tb_apo_input_arbiter
//
// Directed bench for apo_input_arbiter (N2=13, DEPTH=2, CW=8). A table of
// per-edge vectors covers round-robin, single packet, backpressure and
// overflow; hand-written sequences cover multi-drop, saturation, reset in
// HOLD and push/pop on the granted FIFO.
// -----------------------------------------------------------------------------
module tb_apo_input_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [12:0] in_free = '0, in_r1R = '0, in_r2R = '0, in_r1L = '0, in_r2L = '0;
  logic        core_ready = 1'b0;
  logic [12:0] out_pkt;
  logic [4:0]  out_grant;
  logic [4:0]  in_full;
  logic [7:0]  drop_cnt;

  int n_checks = 0;
  int n_errors = 0;

  apo_input_arbiter #(.N2(13), .DEPTH(2), .CW(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_free    (in_free),
    .in_r1R     (in_r1R),
    .in_r2R     (in_r2R),
    .in_r1L     (in_r1L),
    .in_r2L     (in_r2L),
    .core_ready (core_ready),
    .out_pkt    (out_pkt),
    .out_grant  (out_grant),
    .in_full    (in_full),
    .drop_cnt   (drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [12:0] f, a, b, c, d;
    logic        cr;
    logic [12:0] pkt;
    logic [4:0]  g;
    logic [4:0]  full;
    logic [7:0]  drop;
  } vec_t;

  vec_t tv[24];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [12:0] f, a, b, c, d, input logic cr);
    in_free = f; in_r1R = a; in_r2R = b; in_r1L = c; in_r2L = d;
    core_ready = cr;
  endtask

  task automatic expect_all(input string tag, input logic [12:0] pkt,
                            input logic [4:0] g, input logic [4:0] full,
                            input logic [7:0] drop);
    chk({tag, ".out_pkt"},   32'(out_pkt),   32'(pkt));
    chk({tag, ".out_grant"}, 32'(out_grant), 32'(g));
    chk({tag, ".in_full"},   32'(in_full),   32'(full));
    chk({tag, ".drop_cnt"},  32'(drop_cnt),  32'(drop));
  endtask

  initial begin
    // Round-robin from reset: all five loaded together, granted 0..4.
    tv[0]  = '{13'h1101, 13'h1202, 13'h1303, 13'h1404, 13'h1505, 1'b1, 13'h0000, 5'b00000, 5'b00000, 8'd0};
    tv[1]  = '{13'h0, 13'h0, 13'h0, 13'h0, 13'h0, 1'b1, 13'h1101, 5'b00001, 5'b00000, 8'd0};
    tv[2]  = '{13'h0, 13'h0, 13'h0, 13'h0, 13'h0, 1'b1, 13'h1202, 5'b00010, 5'b00000, 8'd0};
    tv[3]  = '{13'h0, 13'h0, 13'h0, 13'h0, 13'h0, 1'b1, 13'h1303, 5'b00100, 5'b00000, 8'd0};
    tv[4]  = '{13'h0, 13'h0, 13'h0, 13'h0, 13'h0, 1'b1, 13'h1404, 5'b01000, 5'b00000, 8'd0};
    tv[5]  = '{13'h0, 13'h0, 13'h0, 13'h0, 13'h0, 1'b1, 13'h1505, 5'b10000, 5'b00000, 8'd0};
    tv[6]  = '{13'h0, 13'h0, 13'h0, 13'h0, 13'h0, 1'b1, 13'h0000, 5'b00000, 5'b00000, 8'd0};
    // Single local packet: visible two edges after it is driven, one cycle.
    tv[7]  = '{13'h1005, 13'h0, 13'h0, 13'h0, 13'h0, 1'b1, 13'h0000, 5'b00000, 5'b00000, 8'd0};
    tv[8]  = '{13'h0, 13'h0, 13'h0, 13'h0, 13'h0, 1'b1, 13'h1005, 5'b00001, 5'b00000, 8'd0};
    tv[9]  = '{13'h0, 13'h0, 13'h0, 13'h0, 13'h0, 1'b1, 13'h0000, 5'b00000, 5'b00000, 8'd0};
    // Backpressure on r1R: EMPTY ignores core_ready; push+pop at v11.
    tv[10] = '{13'h0, 13'h1111, 13'h0, 13'h0, 13'h0, 1'b0, 13'h0000, 5'b00000, 5'b00000, 8'd0};
    tv[11] = '{13'h0, 13'h1112, 13'h0, 13'h0, 13'h0, 1'b0, 13'h1111, 5'b00010, 5'b00000, 8'd0};
    tv[12] = '{13'h0, 13'h1113, 13'h0, 13'h0, 13'h0, 1'b0, 13'h1111, 5'b00010, 5'b00010, 8'd0};
    tv[13] = '{13'h0, 13'h0, 13'h0, 13'h0, 13'h0, 1'b0, 13'h1111, 5'b00010, 5'b00010, 8'd0};
    tv[14] = '{13'h0, 13'h0, 13'h0, 13'h0, 13'h0, 1'b0, 13'h1111, 5'b00010, 5'b00010, 8'd0};
    tv[15] = '{13'h0, 13'h0, 13'h0, 13'h0, 13'h0, 1'b0, 13'h1111, 5'b00010, 5'b00010, 8'd0};
    // Overflow on r2L while output held.
    tv[16] = '{13'h0, 13'h0, 13'h0, 13'h0, 13'h1A01, 1'b0, 13'h1111, 5'b00010, 5'b00010, 8'd0};
    tv[17] = '{13'h0, 13'h0, 13'h0, 13'h0, 13'h1A02, 1'b0, 13'h1111, 5'b00010, 5'b10010, 8'd0};
    tv[18] = '{13'h0, 13'h0, 13'h0, 13'h0, 13'h1A03, 1'b0, 13'h1111, 5'b00010, 5'b10010, 8'd1};
    // Drain: round-robin alternates r2L / r1R after last=1.
    tv[19] = '{13'h0, 13'h0, 13'h0, 13'h0, 13'h0, 1'b1, 13'h1A01, 5'b10000, 5'b00010, 8'd1};
    tv[20] = '{13'h0, 13'h0, 13'h0, 13'h0, 13'h0, 1'b1, 13'h1112, 5'b00010, 5'b00000, 8'd1};
    tv[21] = '{13'h0, 13'h0, 13'h0, 13'h0, 13'h0, 1'b1, 13'h1A02, 5'b10000, 5'b00000, 8'd1};
    tv[22] = '{13'h0, 13'h0, 13'h0, 13'h0, 13'h0, 1'b1, 13'h1113, 5'b00010, 5'b00000, 8'd1};
    tv[23] = '{13'h0, 13'h0, 13'h0, 13'h0, 13'h0, 1'b1, 13'h0000, 5'b00000, 5'b00000, 8'd1};

    // Reset state
    tick();
    tick();
    expect_all("reset", 13'h0, 5'b0, 5'b0, 8'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 24; i++) begin
      drive(tv[i].f, tv[i].a, tv[i].b, tv[i].c, tv[i].d, tv[i].cr);
      tick();
      expect_all($sformatf("vec%0d", i), tv[i].pkt, tv[i].g, tv[i].full, tv[i].drop);
    end

    // Fill all five with core stalled; last=1 so r2R wins the first grant.
    drive(13'h1101, 13'h1202, 13'h1303, 13'h1404, 13'h1505, 1'b0);
    tick();
    expect_all("fill1", 13'h0, 5'b00000, 5'b00000, 8'd1);
    tick();
    expect_all("fill2", 13'h1303, 5'b00100, 5'b11011, 8'd1);
    tick();
    expect_all("fill3", 13'h1303, 5'b00100, 5'b11111, 8'd5);
    tick();
    chk("drop5_in_one_cycle", 32'(drop_cnt), 32'd10);

    // Saturation: +5 per cycle from 10 reaches 255 after 49 edges.
    for (int i = 0; i < 50; i++) tick();
    chk("drop_saturate", 32'(drop_cnt), 32'd255);
    chk("hold_pkt_stalled", 32'(out_pkt), 32'h1303);

    // Asynchronous reset in the middle of a cycle while holding a packet.
    #3;
    rst_n = 1'b0;
    #1;
    expect_all("async_reset", 13'h0, 5'b0, 5'b0, 8'd0);
    drive(13'h0, 13'h0, 13'h0, 13'h0, 13'h0, 1'b0);
    tick();
    rst_n = 1'b1;

    // After reset, free has first priority; then push/pop on granted r1L.
    drive(13'h1101, 13'h1202, 13'h1303, 13'h1404, 13'h1505, 1'b1);
    tick();
    expect_all("rst_load", 13'h0, 5'b00000, 5'b00000, 8'd0);
    drive(13'h0, 13'h0, 13'h0, 13'h0, 13'h0, 1'b1);
    tick();
    expect_all("rst_first", 13'h1101, 5'b00001, 5'b00000, 8'd0);
    tick();
    expect_all("pp_r1R", 13'h1202, 5'b00010, 5'b00000, 8'd0);
    tick();
    expect_all("pp_r2R", 13'h1303, 5'b00100, 5'b00000, 8'd0);
    drive(13'h0, 13'h0, 13'h0, 13'h1444, 13'h0, 1'b1);
    tick();
    expect_all("pp_grant_r1L", 13'h1404, 5'b01000, 5'b00000, 8'd0);
    drive(13'h0, 13'h0, 13'h0, 13'h0, 13'h0, 1'b1);
    tick();
    expect_all("pp_r2L", 13'h1505, 5'b10000, 5'b00000, 8'd0);
    tick();
    expect_all("pp_new_r1L", 13'h1444, 5'b01000, 5'b00000, 8'd0);
    tick();
    expect_all("pp_idle", 13'h0, 5'b00000, 5'b00000, 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
